// File: rtl/sha1_block_engine.sv
// Iterative SHA-1 compression core: 16-word block load, 80 rounds, chaining fold.
// Define SHA1_ROUND_UNROLL2_EN to compute two rounds per cycle (41-cycle busy time).
module sha1_block_engine #(
    parameter logic [159:0] IV = 160'h67452301_EFCDAB89_98BADCFE_10325476_C3D2E1F0
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         iInitial,
    input  logic         iValid,
    input  logic [31:0]  iDat,
    output logic         oReady,
    output logic [159:0] oDat
);

    typedef enum logic [1:0] {S_LOAD, S_ROUND, S_FINAL} state_e;

`ifdef SHA1_ROUND_UNROLL2_EN
    localparam logic [6:0] LAST_T = 7'd78;
`else
    localparam logic [6:0] LAST_T = 7'd79;
`endif

    state_e        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [6:0]    t_q, t_d;
    logic          init_q, init_d;
    logic [31:0]   w_q [16];
    logic [31:0]   w_d [16];
    logic [159:0]  v_q, v_d;
    logic [159:0]  h_q, h_d;
    logic [159:0]  base;

    function automatic logic [159:0] sha1_round(input logic [159:0] v, input logic [6:0] t,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, k;
        {a, b, c, d, e} = v;
        if (t < 7'd20) begin
            f = (b & c) | (~b & d);
            k = 32'h5A827999;
        end else if (t < 7'd40) begin
            f = b ^ c ^ d;
            k = 32'h6ED9EBA1;
        end else if (t < 7'd60) begin
            f = (b & c) | (b & d) | (c & d);
            k = 32'h8F1BBCDC;
        end else begin
            f = b ^ c ^ d;
            k = 32'hCA62C1D6;
        end
        return {{a[26:0], a[31:27]} + f + e + k + w, a, {b[1:0], b[31:2]}, c, d};
    endfunction

    // Chaining value is not latched separately: oDat is frozen until FINAL, so it is still valid.
    assign base   = init_q ? IV : h_q;
    assign oReady = (state_q == S_LOAD);
    assign oDat   = h_q;

    always_comb begin
        logic [31:0] wn0, wn1;
        state_d = state_q;
        idx_d   = idx_q;
        t_d     = t_q;
        init_d  = init_q;
        w_d     = w_q;
        v_d     = v_q;
        h_d     = h_q;
        wn0     = '0;
        wn1     = '0;
        unique case (state_q)
            S_LOAD: begin
                if (iValid) begin
                    for (int unsigned i = 0; i < 15; i++) w_d[i] = w_q[i+1];
                    w_d[15] = iDat;
                    if (iInitial) begin
                        idx_d  = 4'd1;
                        init_d = 1'b1;
                    end else if (idx_q == 4'd0) begin
                        idx_d  = 4'd1;
                        init_d = 1'b0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        if (idx_q == 4'd15) begin
                            state_d = S_ROUND;
                            t_d     = '0;
                            v_d     = base;
                        end
                    end
                end
            end
            S_ROUND: begin
                // Schedule is a shift register: w_q[j] always holds W[t+j].
                wn0 = w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0];
                wn0 = {wn0[30:0], wn0[31]};
`ifdef SHA1_ROUND_UNROLL2_EN
                wn1 = w_q[14] ^ w_q[9] ^ w_q[3] ^ w_q[1];
                wn1 = {wn1[30:0], wn1[31]};
                v_d = sha1_round(sha1_round(v_q, t_q, w_q[0]), t_q + 7'd1, w_q[1]);
                for (int unsigned i = 0; i < 14; i++) w_d[i] = w_q[i+2];
                w_d[14] = wn0;
                w_d[15] = wn1;
                t_d     = t_q + 7'd2;
`else
                v_d = sha1_round(v_q, t_q, w_q[0]);
                for (int unsigned i = 0; i < 15; i++) w_d[i] = w_q[i+1];
                w_d[15] = wn0;
                t_d     = t_q + 7'd1;
`endif
                if (t_q == LAST_T) state_d = S_FINAL;
            end
            S_FINAL: begin
                h_d = {base[159:128] + v_q[159:128], base[127:96] + v_q[127:96],
                       base[95:64]   + v_q[95:64],   base[63:32]  + v_q[63:32],
                       base[31:0]    + v_q[31:0]};
                state_d = S_LOAD;
                idx_d   = '0;
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_LOAD;
            idx_q   <= '0;
            t_q     <= '0;
            init_q  <= 1'b0;
            w_q     <= '{default: '0};
            v_q     <= '0;
            h_q     <= IV;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            t_q     <= t_d;
            init_q  <= init_d;
            w_q     <= w_d;
            v_q     <= v_d;
            h_q     <= h_d;
        end
    end

endmodule

// File: tb/tb_sha1_block_engine.sv
// Directed testbench for sha1_block_engine: FIPS 180 known-answer blocks plus handshake corner cases.
module tb_sha1_block_engine;

    localparam logic [159:0] IV      = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;
    localparam logic [159:0] D_ABC   = 160'hA9993E364706816ABA3E25717850C26C9CD0D89D;
    localparam logic [159:0] D_EMPTY = 160'hDA39A3EE5E6B4B0D3255BFEF95601890AFD80709;
    localparam logic [159:0] D_TWO   = 160'h84983E441C3BD26EBAAE4AA1F95129E5E54670F1;
    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696A, 32'h68696A6B,
                                        32'h696A6B6C, 32'h6A6B6C6D, 32'h6B6C6D6E, 32'h6C6D6E6F,
                                        32'h6D6E6F70, 32'h6E6F7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001C0};
`ifdef SHA1_ROUND_UNROLL2_EN
    localparam int LAT = 41;
`else
    localparam int LAT = 81;
`endif

    typedef struct packed {
        logic         init;
        logic [511:0] blk;
        logic [4:0]   gap;
        logic         chk_dig;
        logic [159:0] dig;
        logic         chk_hold;
        logic [159:0] hold;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         iInitial = 1'b0;
    logic         iValid = 1'b0;
    logic [31:0]  iDat = '0;
    logic         oReady;
    logic [159:0] oDat;

    int checks = 0;
    int failures = 0;

    sha1_block_engine dut (
        .clk(clk), .reset_n(reset_n), .iInitial(iInitial), .iValid(iValid),
        .iDat(iDat), .oReady(oReady), .oDat(oDat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // gap < 16 inserts an iInitial-without-iValid cycle before that word
    task automatic send_block(input logic init, input logic [511:0] blk, input logic [4:0] gap);
        for (int i = 0; i < 16; i++) begin
            if (i == int'(gap)) begin
                @(negedge clk);
                iValid = 1'b0; iInitial = 1'b1; iDat = 32'hDEADBEEF;
            end
            @(negedge clk);
            iValid = 1'b1; iInitial = init && (i == 0); iDat = blk[511-32*i -: 32];
        end
        @(posedge clk);
        #1;
        iValid = 1'b0; iInitial = 1'b0;
    endtask

    task automatic wait_done(input logic junk, input logic chk_hold, input logic [159:0] hold,
                             output int cycles);
        logic hold_ok;
        hold_ok = 1'b1;
        cycles = 0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (oReady) break;
            cycles++;
            if (oDat !== hold) hold_ok = 1'b0;
            if (junk) begin
                iValid = 1'b1; iInitial = 1'($urandom_range(0, 1)); iDat = $urandom;
            end
        end
        iValid = 1'b0; iInitial = 1'b0;
        if (chk_hold) check("hold_during_busy", 160'(hold_ok), 160'd1);
    endtask

    initial begin
        vec_t vecs[4];
        int cyc;

        vecs[0] = '{init: 1'b1, blk: B_EMPTY, gap: 5'd16, chk_dig: 1'b1, dig: D_EMPTY,
                    chk_hold: 1'b1, hold: IV};
        vecs[1] = '{init: 1'b1, blk: B_ABC,   gap: 5'd16, chk_dig: 1'b1, dig: D_ABC,
                    chk_hold: 1'b1, hold: D_EMPTY};
        vecs[2] = '{init: 1'b1, blk: B_TWO1,  gap: 5'd16, chk_dig: 1'b0, dig: '0,
                    chk_hold: 1'b1, hold: D_ABC};
        vecs[3] = '{init: 1'b0, blk: B_TWO2,  gap: 5'd5,  chk_dig: 1'b1, dig: D_TWO,
                    chk_hold: 1'b0, hold: '0};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("reset_oReady", 160'(oReady), 160'd1);
        check("reset_oDat", oDat, IV);

        for (int v = 0; v < 4; v++) begin
            send_block(vecs[v].init, vecs[v].blk, vecs[v].gap);
            wait_done(1'b0, vecs[v].chk_hold, vecs[v].hold, cyc);
            check($sformatf("vec%0d_latency", v), 160'(cyc), 160'(LAT));
            if (vecs[v].chk_dig) check($sformatf("vec%0d_digest", v), oDat, vecs[v].dig);
        end

        // Partial block abandoned by a new iInitial, junk offered while busy
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            iValid = 1'b1; iInitial = (i == 0); iDat = 32'h0BAD0000 + 32'(i);
        end
        send_block(1'b1, B_ABC, 5'd16);
        wait_done(1'b1, 1'b1, D_TWO, cyc);
        check("abort_latency", 160'(cyc), 160'(LAT));
        check("abort_digest", oDat, D_ABC);

        // Reset in the middle of compression
        send_block(1'b1, B_EMPTY, 5'd16);
        repeat (LAT / 2) @(negedge clk);
        check("mid_busy", 160'(oReady), 160'd0);
        reset_n = 1'b0;
        #1;
        check("midreset_oReady", 160'(oReady), 160'd1);
        check("midreset_oDat", oDat, IV);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (LAT + 5) @(negedge clk);
        check("post_reset_idle_oDat", oDat, IV);
        check("post_reset_idle_rdy", 160'(oReady), 160'd1);
        send_block(1'b1, B_ABC, 5'd16);
        wait_done(1'b0, 1'b1, IV, cyc);
        check("post_reset_latency", 160'(cyc), 160'(LAT));
        check("post_reset_digest", oDat, D_ABC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
